mc_controller_v2: RTL and testbench

MC_CONTROLLER_V2 -- requirements
Module: mc_controller_v2

---
 rtl/mc_pkg.sv | 24 ++
 rtl/mc_controller_v2_if.sv | 27 ++
 rtl/mc_wait_timer.sv | 15 +
 rtl/mc_controller_v2.sv | 121 ++++++++++++
 tb/tb_mc_controller_v2.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes, ALU selects and control bundle for mc_controller_v2 (CTRL_IRQ_EN adds IRQ_ENTRY)
package mc_pkg;
  localparam int MEM_TIMEOUT_DEF = 16;
  localparam logic [3:0] OP_LD = 4'd8, OP_ST = 4'd9, OP_JMP = 4'd10, OP_BZ = 4'd11,
                         OP_BN = 4'd12, OP_JAL = 4'd13, OP_JR = 4'd14, OP_QUIT = 4'd15;
  localparam logic [3:0] ALU_LD = 4'd8, ALU_ST = 4'd9, ALU_PC_INC = 4'd10, ALU_PC_BR = 4'd11,
                         ALU_PC_JAL = 4'd12, ALU_PC_JR = 4'd13, ALU_IRQ = 4'd14;
  typedef enum logic [3:0] {
    IFETCH, IFETCH_WAIT, DECODE, EXEC, MEM_LD, MEM_ST, WB_ALU, WB_LD, WB_JAL, BR_TAKE, BR_NOT, HALT
`ifdef CTRL_IRQ_EN
    , IRQ_ENTRY
`endif
  } state_t;
  typedef struct packed {
    logic mem_req, s_addr, en_inst, en_a, en_b, en_f, en_mdr, we_mem;
    logic s_regfile_din, we_regfile, s_regfile_rw, en_pc, halted;
    logic [3:0] alu_op;
  } ctrl_t;
  function automatic logic [3:0] exec_alu(input logic [3:0] op);
    return op == OP_LD ? ALU_LD : op == OP_ST ? ALU_ST : op == OP_JMP ? ALU_PC_BR :
           (op == OP_BZ || op == OP_BN) ? 4'd0 : op == OP_JAL ? ALU_PC_INC :
           op == OP_JR ? ALU_PC_JR : op;
  endfunction
endpackage

// File: rtl/mc_controller_v2_if.sv
// mc_controller_v2_if: controller <-> datapath/memory bus (irq exists only with CTRL_IRQ_EN)
interface mc_controller_v2_if #(parameter int ALU_OP_W = 4);
  logic [3:0] opcode;
  logic zero, neg, mem_ready, mem_req;
  logic s_addr, en_inst, en_a, en_b, en_f, en_mdr, we_mem, s_regfile_din, we_regfile, s_regfile_rw, en_pc;
  logic [ALU_OP_W-1:0] alu_op;
  logic halted, fault;
`ifdef CTRL_IRQ_EN
  logic irq;
`endif
  modport master (
    input opcode, zero, neg, mem_ready,
`ifdef CTRL_IRQ_EN
    input irq,
`endif
    output mem_req, s_addr, en_inst, en_a, en_b, en_f, en_mdr, we_mem, s_regfile_din,
    output we_regfile, s_regfile_rw, en_pc, alu_op, halted, fault
  );
  modport slave (
    output opcode, zero, neg, mem_ready,
`ifdef CTRL_IRQ_EN
    output irq,
`endif
    input mem_req, s_addr, en_inst, en_a, en_b, en_f, en_mdr, we_mem, s_regfile_din,
    input we_regfile, s_regfile_rw, en_pc, alu_op, halted, fault
  );
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: 8-bit memory wait counter; expired flags the LIMIT-th cycle without mem_ready
module mc_wait_timer #(parameter int LIMIT = 16) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] cnt;
  // count stalled cycles of the current wait, restarting whenever outside a wait state
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign expired = inc && cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multicycle CPU control FSM with memory timeout fault; CTRL_IRQ_EN enables the irq entry path
module mc_controller_v2 import mc_pkg::*; #(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int ALU_OP_W = 4
) (
  input logic clk,
  input logic reset,
  mc_controller_v2_if.master bus
);
  state_t state;
  logic [3:0] op_q;
  logic fault, wait_st, tmo;
  ctrl_t c;
  assign wait_st = state inside {IFETCH_WAIT, MEM_LD, MEM_ST};
  mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) timer (
    .clk(clk), .reset(reset), .clr(!wait_st), .inc(wait_st && !bus.mem_ready), .expired(tmo)
  );
  // sequencing, opcode latch and sticky timeout fault
  always_ff @(posedge clk)
    if (reset) begin
      state <= IFETCH;
      op_q <= '0;
      fault <= 1'b0;
    end else if (tmo) begin
      state <= HALT;
      fault <= 1'b1;
    end else
      case (state)
`ifdef CTRL_IRQ_EN
        IFETCH: state <= bus.irq ? IRQ_ENTRY : IFETCH_WAIT;
`else
        IFETCH: state <= IFETCH_WAIT;
`endif
        IFETCH_WAIT: state <= bus.mem_ready ? DECODE : IFETCH_WAIT;
        DECODE: begin
          op_q <= bus.opcode;
          state <= bus.opcode == OP_QUIT ? HALT : EXEC;
        end
        EXEC: state <= !op_q[3] ? WB_ALU : op_q == OP_LD ? MEM_LD : op_q == OP_ST ? MEM_ST :
                       op_q == OP_BZ ? (bus.zero ? BR_TAKE : BR_NOT) :
                       op_q == OP_BN ? (bus.neg ? BR_TAKE : BR_NOT) :
                       op_q == OP_JAL ? WB_JAL : IFETCH;
        MEM_LD: state <= bus.mem_ready ? WB_LD : MEM_LD;
        MEM_ST: state <= bus.mem_ready ? IFETCH : MEM_ST;
        HALT: state <= HALT;
        default: state <= IFETCH;
      endcase
  // control decode from state and latched opcode; memory strobes fire in the mem_ready cycle
  always_comb begin
    c = '0;
    case (state)
      IFETCH: c.mem_req = 1'b1;
      IFETCH_WAIT: begin
        c.mem_req = 1'b1;
        c.en_inst = bus.mem_ready;
      end
      DECODE: begin
        c.en_a = 1'b1;
        c.en_b = 1'b1;
      end
      EXEC: begin
        c.alu_op = exec_alu(op_q);
        c.en_f = op_q < OP_JMP || op_q == OP_JAL;
        c.en_pc = op_q == OP_JMP || op_q == OP_JR;
      end
      MEM_LD: begin
        c.mem_req = 1'b1;
        c.s_addr = 1'b1;
        c.en_mdr = bus.mem_ready;
      end
      MEM_ST: begin
        c.mem_req = 1'b1;
        c.s_addr = 1'b1;
        c.we_mem = 1'b1;
        c.en_pc = bus.mem_ready;
        c.alu_op = bus.mem_ready ? ALU_PC_INC : 4'd0;
      end
      WB_ALU, WB_LD: begin
        c.we_regfile = 1'b1;
        c.s_regfile_din = state == WB_LD;
        c.alu_op = ALU_PC_INC;
        c.en_pc = 1'b1;
      end
      WB_JAL: begin
        c.we_regfile = 1'b1;
        c.s_regfile_rw = 1'b1;
        c.alu_op = ALU_PC_JAL;
        c.en_pc = 1'b1;
      end
      BR_TAKE, BR_NOT: begin
        c.alu_op = state == BR_TAKE ? ALU_PC_BR : ALU_PC_INC;
        c.en_pc = 1'b1;
      end
`ifdef CTRL_IRQ_EN
      IRQ_ENTRY: begin
        c.we_regfile = 1'b1;
        c.s_regfile_rw = 1'b1;
        c.alu_op = ALU_IRQ;
        c.en_pc = 1'b1;
      end
`endif
      HALT: c.halted = 1'b1;
      default: ;
    endcase
  end
  assign bus.mem_req = c.mem_req;
  assign bus.s_addr = c.s_addr;
  assign bus.en_inst = c.en_inst;
  assign bus.en_a = c.en_a;
  assign bus.en_b = c.en_b;
  assign bus.en_f = c.en_f;
  assign bus.en_mdr = c.en_mdr;
  assign bus.we_mem = c.we_mem;
  assign bus.s_regfile_din = c.s_regfile_din;
  assign bus.we_regfile = c.we_regfile;
  assign bus.s_regfile_rw = c.s_regfile_rw;
  assign bus.en_pc = c.en_pc;
  assign bus.alu_op = ALU_OP_W'(c.alu_op);
  assign bus.halted = c.halted;
  assign bus.fault = fault;
endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: instruction-level reference model driving per-cycle expected control vectors
module tb_mc_controller_v2;
  localparam logic [21:0] MREQ = 22'h200000, SADDR = 22'h100000, INST = 22'h080000, EA = 22'h040000,
                          EB = 22'h020000, EF = 22'h010000, MDR = 22'h008000, WEM = 22'h004000,
                          DIN = 22'h002000, WRF = 22'h001000, RW = 22'h000800, PC = 22'h000400,
                          HLT = 22'h000200, FLT = 22'h000100;
  typedef struct {
    logic [21:0] e;
    logic r;
    logic [3:0] o;
    logic z, n, i;
  } cyc_t;
  logic clk = 1'b0, reset = 1'b1, rst_t = 1'b1;
  int total = 0, bad = 0;
  string tag;
  cyc_t q[$];
  mc_controller_v2_if #(.ALU_OP_W(6)) bus();
  mc_controller_v2_if #(.ALU_OP_W(4)) bus_t();
  mc_controller_v2 #(.ALU_OP_W(6)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  mc_controller_v2 #(.MEM_TIMEOUT(4), .ALU_OP_W(4)) tdut (.clk(clk), .reset(rst_t), .bus(bus_t.master));
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [21:0] outv();
    return {bus.mem_req, bus.s_addr, bus.en_inst, bus.en_a, bus.en_b, bus.en_f, bus.en_mdr, bus.we_mem,
            bus.s_regfile_din, bus.we_regfile, bus.s_regfile_rw, bus.en_pc, bus.halted, bus.fault,
            2'b00, bus.alu_op};
  endfunction

  task automatic chk(input string t, input logic [21:0] got, input logic [21:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", t, got, exp);
    end
  endtask

  task automatic add(input logic [21:0] e, input logic r);
    q.push_back('{e, r, 4'($urandom), rb(), rb(), 1'b0});
  endtask

  // expected cycle trace of one instruction: fd/md = stalled cycles before mem_ready
  task automatic instr(input int op, input int fd, input int md, input logic z, input logic n);
    add(MREQ, 1'b0);
    repeat (fd) add(MREQ, 1'b0);
    add(MREQ | INST, 1'b1);
    add(EA | EB, rb());
    q[$].o = 4'(op);
    if (op == 15) return;
    if (op < 8) begin
      add(EF | 22'(op), rb());
      add(WRF | PC | 22'd10, rb());
    end else if (op == 8) begin
      add(EF | 22'd8, rb());
      repeat (md) add(MREQ | SADDR, 1'b0);
      add(MREQ | SADDR | MDR, 1'b1);
      add(WRF | DIN | PC | 22'd10, rb());
    end else if (op == 9) begin
      add(EF | 22'd9, rb());
      repeat (md) add(MREQ | SADDR | WEM, 1'b0);
      add(MREQ | SADDR | WEM | PC | 22'd10, 1'b1);
    end else if (op == 10) add(PC | 22'd11, rb());
    else if (op == 11 || op == 12) begin
      add(22'd0, rb());
      q[$].z = z;
      q[$].n = n;
      add(PC | ((op == 11 ? z : n) ? 22'd11 : 22'd10), rb());
    end else if (op == 13) begin
      add(EF | 22'd10, rb());
      add(WRF | RW | PC | 22'd12, rb());
    end else add(PC | 22'd13, rb());
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.mem_ready = c.r;
      bus.opcode = c.o;
      bus.zero = c.z;
      bus.neg = c.n;
`ifdef CTRL_IRQ_EN
      bus.irq = c.i;
`endif
      @(negedge clk);
      chk(tag, outv(), c.e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.neg = 1'b0;
    bus_t.mem_ready = 1'b0;
    bus_t.opcode = '0;
    bus_t.zero = 1'b0;
    bus_t.neg = 1'b0;
`ifdef CTRL_IRQ_EN
    bus.irq = 1'b0;
    bus_t.irq = 1'b0;
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", outv(), MREQ);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tag = "add_fetch_wait2";
    instr(0, 2, 0, 1'b0, 1'b0);
    run_q();
    tag = "ld_wait5";
    instr(8, 0, 5, 1'b0, 1'b0);
    run_q();
    tag = "bz_taken";
    instr(11, 1, 0, 1'b1, 1'b0);
    run_q();
    tag = "bz_not";
    instr(11, 0, 0, 1'b0, 1'b1);
    run_q();
    tag = "bn_taken_not";
    instr(12, 0, 0, 1'b0, 1'b1);
    instr(12, 0, 0, 1'b1, 1'b0);
    run_q();
    tag = "max_wait_no_timeout";
    instr(13, 15, 0, 1'b0, 1'b0);
    instr(8, 0, 15, 1'b0, 1'b0);
    instr(9, 15, 15, 1'b0, 1'b0);
    run_q();
    tag = "random_instr";
    for (int k = 0; k < 40; k++)
      instr($urandom_range(0, 14), $urandom_range(0, 4), $urandom_range(0, 4), rb(), rb());
    run_q();
`ifdef CTRL_IRQ_EN
    tag = "irq_entry";
    add(MREQ, 1'b0);
    q[$].i = 1'b1;
    add(WRF | RW | PC | 22'd14, rb());
    instr(1, 0, 0, 1'b0, 1'b0);
    run_q();
`endif
    tag = "st_before_reset";
    instr(9, 0, 10, 1'b0, 1'b0);
    while (q.size() > 7) void'(q.pop_back());
    run_q();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("st_reset_cycle", outv(), MREQ | SADDR | WEM);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tag = "after_st_reset";
    instr(2, 1, 0, 1'b0, 1'b0);
    run_q();
    tag = "quit_halt";
    instr(15, 0, 0, 1'b0, 1'b0);
    repeat (20) add(HLT, rb());
    run_q();
    rst_t = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("timeout4", 22'({bus_t.mem_req, bus_t.en_inst, bus_t.halted, bus_t.fault}),
          k < 5 ? 22'b1000 : 22'b0011);
      @(posedge clk);
      #1;
    end
    rst_t = 1'b1;
    @(posedge clk);
    #1;
    rst_t = 1'b0;
    @(negedge clk);
    chk("timeout_reset", 22'({bus_t.mem_req, bus_t.en_inst, bus_t.halted, bus_t.fault}), 22'b1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
